// File: rtl/fib_result_checker.sv
// fib_result_checker: watches a result stream and checks it against a Fibonacci
// recurrence modulo 2^WIDTH, after a fill delay and two seed samples.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   result       value under check
//   result_valid sample qualifier (ignored while waiting for datapath fill)
//   done         check sequence complete, sticky until rst
//   pass         done with no mismatches
//   fail         at least one mismatch seen, sticky
//   check_cnt    recurrence comparisons performed (seeds excluded)
//   err_cnt      mismatches including seeds, saturating
//   bad_index    sample index of the first mismatch
//   bad_value    received value at the first mismatch
//   bad_expect   expected value at the first mismatch
module fib_result_checker #(
    parameter int unsigned     WIDTH       = 32,
    parameter int unsigned     LAT         = 2,
    parameter int unsigned     NUM_CHECKS  = 16,
    parameter int unsigned     CHECK_SEEDS = 1,
    parameter logic [WIDTH-1:0] SEED_A     = 1,
    parameter logic [WIDTH-1:0] SEED_B     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] result,
    input  logic             result_valid,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [15:0]      check_cnt,
    output logic [15:0]      err_cnt,
    output logic [15:0]      bad_index,
    output logic [WIDTH-1:0] bad_value,
    output logic [WIDTH-1:0] bad_expect
);

    typedef enum logic [2:0] {StWait, StSeed0, StSeed1, StCheck, StDone} state_e;

    // With no fill delay the first sample is taken on the first edge after reset.
    localparam state_e      ResetState = (LAT == 0) ? StSeed0 : StWait;
    localparam logic [31:0] LatLast    = 32'(LAT) - 32'd1;
    localparam logic [15:0] LastCheck  = 16'(NUM_CHECKS - 1);
    localparam logic        SeedsChk   = (CHECK_SEEDS != 0);

    state_e           state_q, state_d;
    logic [31:0]      wait_cnt_q, wait_cnt_d;
    logic [15:0]      idx_q, idx_d;
    logic [WIDTH-1:0] g0_q, g0_d, g1_q, g1_d;
    logic             done_q, done_d, pass_q, pass_d, fail_q, fail_d;
    logic [15:0]      check_cnt_q, check_cnt_d, err_cnt_q, err_cnt_d;
    logic [15:0]      bad_index_q, bad_index_d;
    logic [WIDTH-1:0] bad_value_q, bad_value_d, bad_expect_q, bad_expect_d;

    logic             cmp_en;
    logic [WIDTH-1:0] cmp_expect;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        idx_d        = idx_q;
        g0_d         = g0_q;
        g1_d         = g1_q;
        done_d       = done_q;
        fail_d       = fail_q;
        check_cnt_d  = check_cnt_q;
        err_cnt_d    = err_cnt_q;
        bad_index_d  = bad_index_q;
        bad_value_d  = bad_value_q;
        bad_expect_d = bad_expect_q;
        cmp_en       = 1'b0;
        cmp_expect   = '0;

        case (state_q)
            StWait: begin
                if (wait_cnt_q == LatLast) begin
                    state_d = StSeed0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            StSeed0: begin
                if (result_valid) begin
                    idx_d      = idx_q + 16'd1;
                    g0_d       = SeedsChk ? SEED_A : result;
                    cmp_en     = SeedsChk;
                    cmp_expect = SEED_A;
                    state_d    = StSeed1;
                end
            end
            StSeed1: begin
                if (result_valid) begin
                    idx_d      = idx_q + 16'd1;
                    g1_d       = SeedsChk ? SEED_B : result;
                    cmp_en     = SeedsChk;
                    cmp_expect = SEED_B;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                if (result_valid) begin
                    // Golden model advances on its own values only, never on received data.
                    cmp_expect  = g1_q + g0_q;
                    cmp_en      = 1'b1;
                    g0_d        = g1_q;
                    g1_d        = cmp_expect;
                    idx_d       = idx_q + 16'd1;
                    check_cnt_d = check_cnt_q + 16'd1;
                    if (check_cnt_q == LastCheck) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StDone: ;
            default: state_d = ResetState;
        endcase

        if (cmp_en && (result != cmp_expect)) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            fail_d = 1'b1;
            if (!fail_q) begin
                bad_index_d  = idx_q;
                bad_value_d  = result;
                bad_expect_d = cmp_expect;
            end
        end

        pass_d = done_d & ~fail_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ResetState;
            wait_cnt_q   <= '0;
            idx_q        <= '0;
            g0_q         <= '0;
            g1_q         <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            check_cnt_q  <= '0;
            err_cnt_q    <= '0;
            bad_index_q  <= '0;
            bad_value_q  <= '0;
            bad_expect_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            idx_q        <= idx_d;
            g0_q         <= g0_d;
            g1_q         <= g1_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            check_cnt_q  <= check_cnt_d;
            err_cnt_q    <= err_cnt_d;
            bad_index_q  <= bad_index_d;
            bad_value_q  <= bad_value_d;
            bad_expect_q <= bad_expect_d;
        end
    end

    assign done       = done_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign check_cnt  = check_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign bad_index  = bad_index_q;
    assign bad_value  = bad_value_q;
    assign bad_expect = bad_expect_q;

endmodule

// File: tb/tb_fib_result_checker.sv
// Bench for fib_result_checker: instance A uses default parameters (seeds checked),
// instance B takes its seeds from the stream and performs only NC_B comparisons.
module tb_fib_result_checker;

    localparam int unsigned LAT  = 2;
    localparam int          NC_A = 16;
    localparam int          NC_B = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] result = '0;
    logic        result_valid = 1'b0;

    logic        a_done, a_pass, a_fail, b_done, b_pass, b_fail;
    logic [15:0] a_cc, a_ec, a_bi, b_cc, b_ec, b_bi;
    logic [31:0] a_bv, a_be, b_bv, b_be;

    fib_result_checker #(.WIDTH(32), .LAT(LAT), .NUM_CHECKS(NC_A), .CHECK_SEEDS(1),
                         .SEED_A(32'd1), .SEED_B(32'd1)) u_a (
        .clk(clk), .rst(rst), .result(result), .result_valid(result_valid),
        .done(a_done), .pass(a_pass), .fail(a_fail), .check_cnt(a_cc), .err_cnt(a_ec),
        .bad_index(a_bi), .bad_value(a_bv), .bad_expect(a_be)
    );

    fib_result_checker #(.WIDTH(32), .LAT(LAT), .NUM_CHECKS(NC_B), .CHECK_SEEDS(0),
                         .SEED_A(32'd1), .SEED_B(32'd1)) u_b (
        .clk(clk), .rst(rst), .result(result), .result_valid(result_valid),
        .done(b_done), .pass(b_pass), .fail(b_fail), .check_cnt(b_cc), .err_cnt(b_ec),
        .bad_index(b_bi), .bad_value(b_bv), .bad_expect(b_be)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] stim [0:31];
    int          n_stim = 0;
    int          acc = 0;
    int          edge_no = 0;
    int          done_edge = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the golden sequence is built from the seeds by plain addition; the outputs
    // are then a pure function of how many samples have been accepted so far.
    task automatic expect_inst(input string nm, input bit cs, input int nc,
                               input logic d, input logic p, input logic f,
                               input logic [15:0] cc, input logic [15:0] ec,
                               input logic [15:0] bi, input logic [31:0] bv,
                               input logic [31:0] be);
        logic [31:0] gold [0:31];
        int eff, nerr, first;
        logic [31:0] e_bi, e_bv, e_be;
        gold[0] = cs ? 32'd1 : stim[0];
        gold[1] = cs ? 32'd1 : stim[1];
        for (int i = 2; i < 32; i++) gold[i] = gold[i-1] + gold[i-2];
        eff   = (acc < nc + 2) ? acc : nc + 2;
        nerr  = 0;
        first = -1;
        for (int i = 0; i < eff; i++) begin
            if (stim[i] !== gold[i]) begin
                nerr++;
                if (first < 0) first = i;
            end
        end
        e_bi = '0; e_bv = '0; e_be = '0;
        if (first >= 0) begin
            e_bi = 32'(first);
            e_bv = stim[first];
            e_be = gold[first];
        end
        chk({nm, ".check_cnt"}, 32'(cc), (eff > 2) ? 32'(eff - 2) : 32'd0);
        chk({nm, ".err_cnt"}, 32'(ec), 32'(nerr));
        chk({nm, ".done"}, 32'(d), (eff == nc + 2) ? 32'd1 : 32'd0);
        chk({nm, ".fail"}, 32'(f), (nerr > 0) ? 32'd1 : 32'd0);
        chk({nm, ".pass"}, 32'(p), (eff == nc + 2 && nerr == 0) ? 32'd1 : 32'd0);
        chk({nm, ".bad_index"}, 32'(bi), e_bi);
        chk({nm, ".bad_value"}, bv, e_bv);
        chk({nm, ".bad_expect"}, be, e_be);
    endtask

    task automatic check_all();
        expect_inst("A", 1'b1, NC_A, a_done, a_pass, a_fail, a_cc, a_ec, a_bi, a_bv, a_be);
        expect_inst("B", 1'b0, NC_B, b_done, b_pass, b_fail, b_cc, b_ec, b_bi, b_bv, b_be);
    endtask

    task automatic fill_fib(input logic [31:0] s0, input logic [31:0] s1);
        stim[0] = s0;
        stim[1] = s1;
        for (int i = 2; i < 32; i++) stim[i] = stim[i-1] + stim[i-2];
        n_stim = 20;
    endtask

    // Reset, pass the fill window with junk, then feed stim[] with optional idle gaps.
    task automatic run(input int gap_at, input int gap_len, input bit rand_gaps,
                       input int abort_at);
        int ng;
        done_edge    = 0;
        rst          = 1'b1;
        result_valid = 1'b1;
        result       = $urandom;
        step();
        acc = 0;
        check_all();
        rst     = 1'b0;
        edge_no = 0;
        for (int c = 0; c < int'(LAT); c++) begin
            result       = $urandom;
            result_valid = 1'($urandom_range(0, 1));
            step();
            edge_no++;
            check_all();
        end
        for (int k = 0; k < n_stim; k++) begin
            if (abort_at != 0 && acc == abort_at) return;
            ng = 0;
            if (k == gap_at) ng = gap_len;
            else if (rand_gaps && $urandom_range(0, 3) == 0) ng = int'($urandom_range(1, 2));
            for (int g = 0; g < ng; g++) begin
                result_valid = 1'b0;
                result       = $urandom;
                step();
                edge_no++;
                check_all();
            end
            result       = stim[k];
            result_valid = 1'b1;
            step();
            edge_no++;
            acc++;
            check_all();
            if (a_done && done_edge == 0) done_edge = edge_no;
        end
        result_valid = 1'b0;
    endtask

    initial begin
        // Correct stream: done at edge LAT+NC+2.
        fill_fib(32'd1, 32'd1);
        run(-1, 0, 1'b0, 0);
        chk("s1.done_edge", 32'(done_edge), 32'd20);
        chk("s1.pass", 32'(a_pass), 32'd1);

        // Single corrupted sample at index 7.
        fill_fib(32'd1, 32'd1);
        stim[7] = 32'd22;
        run(-1, 0, 1'b0, 0);
        chk("s2.bad_index", 32'(a_bi), 32'd7);
        chk("s2.bad_value", a_bv, 32'd22);
        chk("s2.bad_expect", a_be, 32'd21);
        chk("s2.err_cnt", 32'(a_ec), 32'd1);

        // Three idle cycles before index 5 delay done by three edges.
        fill_fib(32'd1, 32'd1);
        run(5, 3, 1'b0, 0);
        chk("s3.done_edge", 32'(done_edge), 32'd23);
        chk("s3.check_cnt", 32'(a_cc), 32'd16);

        // Seeds taken from the stream, with wrap-around in the sum.
        fill_fib(32'h8000_0000, 32'h8000_0000);
        chk("s4.stim2", stim[2], 32'd0);
        run(-1, 0, 1'b0, 0);
        chk("s4.b_err_cnt", 32'(b_ec), 32'd0);
        chk("s4.b_pass", 32'(b_pass), 32'd1);

        // Wrong first seed.
        fill_fib(32'd1, 32'd1);
        stim[0] = 32'd2;
        run(-1, 0, 1'b0, 0);
        chk("s5.bad_index", 32'(a_bi), 32'd0);
        chk("s5.bad_value", a_bv, 32'd2);
        chk("s5.bad_expect", a_be, 32'd1);

        // Abort after five comparisons, then a full clean run.
        fill_fib(32'd1, 32'd1);
        run(-1, 0, 1'b0, 7);
        chk("s6.check_cnt_pre", 32'(a_cc), 32'd5);
        run(-1, 0, 1'b0, 0);
        chk("s6.pass", 32'(a_pass), 32'd1);
        chk("s6.check_cnt", 32'(a_cc), 32'd16);

        // Random seeds, random single-bit corruptions, random idle gaps.
        for (int r = 0; r < 8; r++) begin
            if (r[0]) fill_fib(32'd1, 32'd1);
            else fill_fib($urandom, $urandom);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                int idx;
                idx = int'($urandom_range(0, 19));
                stim[idx] = stim[idx] ^ (32'd1 << $urandom_range(0, 31));
            end
            run(-1, 0, 1'b1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
